// File: rtl/hilo_seq_pkg.sv
// Shared types and default opcodes for the HI/LO move sequencer.
package hilo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        F0,
        F1,
        F2,
        EX,
        TRAP
    } state_t;

    localparam logic [4:0] OP_MTHI_DEF = 5'b10101;
    localparam logic [4:0] OP_MTLO_DEF = 5'b10110;
    localparam logic [4:0] OP_MFHI_DEF = 5'b10111;
    localparam logic [4:0] OP_MFLO_DEF = 5'b11000;

endpackage

// File: rtl/hilo_op_decode.sv
// Combinational opcode classifier for the HI/LO move group.
module hilo_op_decode
    import hilo_seq_pkg::*;
#(
    parameter int unsigned     OPW     = 5,
    parameter logic [OPW-1:0]  OP_MTHI = OPW'(OP_MTHI_DEF),
    parameter logic [OPW-1:0]  OP_MTLO = OPW'(OP_MTLO_DEF),
    parameter logic [OPW-1:0]  OP_MFHI = OPW'(OP_MFHI_DEF),
    parameter logic [OPW-1:0]  OP_MFLO = OPW'(OP_MFLO_DEF)
) (
    input  logic [OPW-1:0] opcode,
    output logic           legal,
    output logic           is_from,
    output logic           is_hi
);

    always_comb begin
        legal   = 1'b0;
        is_from = 1'b0;
        is_hi   = 1'b0;
        if (opcode == OP_MTHI) begin
            legal = 1'b1;
            is_hi = 1'b1;
        end else if (opcode == OP_MTLO) begin
            legal = 1'b1;
        end else if (opcode == OP_MFHI) begin
            legal   = 1'b1;
            is_from = 1'b1;
            is_hi   = 1'b1;
        end else if (opcode == OP_MFLO) begin
            legal   = 1'b1;
            is_from = 1'b1;
        end
    end

endmodule

// File: rtl/hilo_move_sequencer.sv
// Fetch/decode/execute sequencer for mfhi/mflo/mthi/mtlo with memory wait and trap.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module hilo_move_sequencer
    import hilo_seq_pkg::*;
#(
    parameter int unsigned     BITS    = 32,
    parameter int unsigned     OPW     = 5,
    parameter logic [OPW-1:0]  OP_MTHI = OPW'(OP_MTHI_DEF),
    parameter logic [OPW-1:0]  OP_MTLO = OPW'(OP_MTLO_DEF),
    parameter logic [OPW-1:0]  OP_MFHI = OPW'(OP_MFHI_DEF),
    parameter logic [OPW-1:0]  OP_MFLO = OPW'(OP_MFLO_DEF),
    parameter int unsigned     CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            mem_ready,
    input  logic [BITS-1:0] IRVal,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            RZin,
    output logic            RZout,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Gra,
    output logic            Rin,
    output logic            Rout,
    output logic            HILOin,
    output logic            HILOout,
    output logic            hilo_sel,
    output logic            busy,
    output logic            done,
    output logic            illegal
`ifdef INSTR_COUNT_EN
    ,
    output logic [CNTW-1:0] retired
`endif
);

    state_t           state;
    state_t           state_nx;
    logic [OPW-1:0]   op_q;
    logic [OPW-1:0]   op_field;
    logic [OPW-1:0]   dec_op;
    logic             f1_first;
    logic             dec_legal;
    logic             dec_from;
    logic             dec_hi;
    logic             unused_ir;

    assign op_field  = IRVal[BITS-1 -: OPW];
    assign unused_ir = ^IRVal[BITS-OPW-1:0];

    // One decoder serves both uses: in F2 it classifies the incoming IR to
    // choose EX vs TRAP; elsewhere it classifies the latched opcode.
    assign dec_op = (state == F2) ? op_field : op_q;

    hilo_op_decode #(
        .OPW     (OPW),
        .OP_MTHI (OP_MTHI),
        .OP_MTLO (OP_MTLO),
        .OP_MFHI (OP_MFHI),
        .OP_MFLO (OP_MFLO)
    ) u_decode (
        .opcode  (dec_op),
        .legal   (dec_legal),
        .is_from (dec_from),
        .is_hi   (dec_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            f1_first <= 1'b0;
        end else begin
            state    <= state_nx;
            f1_first <= (state == F0);
            if (state == F2) begin
                op_q <= op_field;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run ? F0 : IDLE;
            F0:      state_nx = F1;
            F1:      state_nx = mem_ready ? F2 : F1;
            F2:      state_nx = dec_legal ? EX : TRAP;
            EX:      state_nx = run ? F0 : IDLE;
            TRAP:    state_nx = TRAP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        RZin     = 1'b0;
        RZout    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Gra      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        HILOin   = 1'b0;
        HILOout  = 1'b0;
        hilo_sel = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        busy     = (state != IDLE) && (state != TRAP);
        case (state)
            F0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            F1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                RZout = f1_first;
                PCin  = f1_first;
            end
            F2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            EX: begin
                if (dec_legal) begin
                    Gra      = 1'b1;
                    hilo_sel = dec_hi;
                    done     = 1'b1;
                    HILOout  = dec_from;
                    Rin      = dec_from;
                    Rout     = !dec_from;
                    HILOin   = !dec_from;
                end
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (done) begin
            retired <= retired + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hilo_move_sequencer.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_hilo_move_sequencer;

`ifdef INSTR_COUNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    localparam logic [4:0] MTHI = 5'b10101;
    localparam logic [4:0] MTLO = 5'b10110;
    localparam logic [4:0] MFHI = 5'b10111;
    localparam logic [4:0] MFLO = 5'b11000;
    localparam logic [4:0] BAD  = 5'b00001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] IRVal = '0;
    logic PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Rin, Rout, HILOin, HILOout, hilo_sel, busy, done, illegal;
`ifdef INSTR_COUNT_EN
    logic [CW-1:0] retired;
`endif

    hilo_move_sequencer #(.CNTW(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .IRVal(IRVal),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZout(RZout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Rin(Rin), .Rout(Rout), .HILOin(HILOin), .HILOout(HILOout),
        .hilo_sel(hilo_sel), .busy(busy), .done(done), .illegal(illegal)
`ifdef INSTR_COUNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: phase of the instruction lifecycle.
    // 0 idle, 1 address out, 2 first memory cycle, 3 extra memory cycle,
    // 4 IR load, 5 execute, 6 trapped.
    int          ph = 0;
    logic [4:0]  m_op = '0;
    int          m_cnt = 0;

    function automatic bit is_legal(input logic [4:0] op);
        return (op == MTHI) || (op == MTLO) || (op == MFHI) || (op == MFLO);
    endfunction

    // {PCout,MARin,IncPC,RZin,RZout,PCin,Read,MDRin,MDRout,IRin,
    //  Gra,Rin,Rout,HILOin,HILOout,sel,busy,done,illegal}
    function automatic logic [18:0] model_vec(input int p, input logic [4:0] op);
        bit from, hi;
        from = (op == MFHI) || (op == MFLO);
        hi   = (op == MFHI) || (op == MTHI);
        case (p)
            1: return 19'b1111_000000_00000_0_100;
            2: return 19'b0000_111100_00000_0_100;
            3: return 19'b0000_001100_00000_0_100;
            4: return 19'b0000_000011_00000_0_100;
            5: return {10'b0, 1'b1, from, !from, !from, from, hi, 3'b110};
            6: return 19'b0000_000000_00000_0_001;
            default: return '0;
        endcase
    endfunction

    function automatic logic [18:0] dut_vec();
        return {PCout, MARin, IncPC, RZin, RZout, PCin, Read, MDRin, MDRout, IRin,
                Gra, Rin, Rout, HILOin, HILOout, hilo_sel & (HILOin | HILOout),
                busy, done, illegal};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            ph = 0;
            m_op = '0;
            m_cnt = 0;
        end else begin
            case (ph)
                0: if (run) ph = 1;
                1: ph = 2;
                2, 3: ph = mem_ready ? 4 : 3;
                4: begin
                    m_op = IRVal[31:27];
                    ph = is_legal(m_op) ? 5 : 6;
                end
                5: begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    ph = run ? 1 : 0;
                end
                default: ;
            endcase
        end
    end

    int done_q[$];
    bit sel_q[$];
    int read_cnt = 0, pcin_cnt = 0, rzout_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cycle_outputs", {13'b0, dut_vec()}, {13'b0, model_vec(ph, m_op)});
            check("one_bus_driver", {31'b0, (PCout + RZout + MDRout + HILOout + Rout) <= 1}, 32'd1);
`ifdef INSTR_COUNT_EN
            check("retired_count", {{(32-CW){1'b0}}, retired}, m_cnt);
`endif
            if (done) begin
                done_q.push_back(cyc);
                sel_q.push_back(hilo_sel);
            end
            if (Read)  read_cnt++;
            if (PCin)  pcin_cnt++;
            if (RZout) rzout_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stats();
        done_q.delete();
        sel_q.delete();
        read_cnt = 0;
        pcin_cnt = 0;
        rzout_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check("done_timeout", 0, 1);
    endtask

    int c0, dc, n;
    logic [4:0] ops [4];

    initial begin
        // Reset state
        do_reset();
        check("reset_outputs", {13'b0, dut_vec()}, 0);

        // mfhi with zero memory wait
        clear_stats();
        IRVal = {MFHI, 27'h0};
        mem_ready = 1'b1;
        run = 1'b1;
        c0 = cyc;
        tick(1);
        run = 1'b0;
        wait_done(20, dc);
        check("mfhi_latency", dc - c0 + 1, 5);
        check("mfhi_ex_strobes", {28'b0, HILOout, Gra, Rin, hilo_sel}, 32'hF);
        tick(2);

        // mtlo with three wait cycles in F1
        clear_stats();
        IRVal = {MTLO, 27'h155};
        mem_ready = 1'b0;
        run = 1'b1;
        c0 = cyc;
        tick(1);
        run = 1'b0;
        tick(1);
        tick(3);
        mem_ready = 1'b1;
        wait_done(20, dc);
        check("mtlo_ex_strobes", {29'b0, Rout, HILOin, hilo_sel}, 32'b110);
        check("mtlo_latency", dc - c0 + 1, 8);
        tick(2);
        check("mtlo_read_cycles", read_cnt, 4);
        check("mtlo_pcin_cycles", pcin_cnt, 1);
        check("mtlo_rzout_cycles", rzout_cnt, 1);

        // Illegal opcode traps until reset
        clear_stats();
        IRVal = {BAD, 27'h0};
        run = 1'b1;
        for (int i = 0; i < 20 && illegal !== 1'b1; i++) @(negedge clk);
        tick(10);
        check("trap_illegal_held", {31'b0, illegal}, 1);
        check("trap_no_done", done_q.size(), 0);
        check("trap_not_busy", {31'b0, busy}, 0);
        do_reset();
        check("trap_reset_outputs", {13'b0, dut_vec()}, 0);

        // Back-to-back mfhi, mflo, mthi, mtlo
        clear_stats();
        ops[0] = MFHI; ops[1] = MFLO; ops[2] = MTHI; ops[3] = MTLO;
        mem_ready = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && ph != 4; i++) @(negedge clk);
            IRVal = {ops[k], 27'h0};
            if (k == 3) run = 1'b0;
            tick(1);
        end
        tick(3);
        check("b2b_done_count", done_q.size(), 4);
        for (int k = 1; k < 4 && k < done_q.size(); k++)
            check("b2b_done_interval", done_q[k] - done_q[k-1], 4);
        for (int k = 0; k < 4 && k < sel_q.size(); k++)
            check("b2b_hilo_sel", {31'b0, sel_q[k]}, (k % 2 == 0) ? 1 : 0);

        // Reset during the F1 wait, with mem_ready also high
        IRVal = {MFHI, 27'h0};
        mem_ready = 1'b0;
        run = 1'b1;
        tick(3);
        reset = 1'b1;
        mem_ready = 1'b1;
        tick(1);
        reset = 1'b0;
        run = 1'b0;
        check("f1_reset_outputs", {13'b0, dut_vec()}, 0);
        clear_stats();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        check("restart_f0", {28'b0, PCout, MARin, IncPC, RZin}, 32'hF);
        wait_done(20, dc);
        check("restart_done", {31'b0, done}, 1);
        tick(2);

`ifdef INSTR_COUNT_EN
        // Counter wraps after 16 instructions; illegal ones are not counted
        do_reset();
        IRVal = {MFHI, 27'h0};
        mem_ready = 1'b1;
        run = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 17; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n++;
                if (n == 17) run = 1'b0;
            end
        end
        tick(2);
        check("cnt_wrap", {{(32-CW){1'b0}}, retired}, 1);
        IRVal = {BAD, 27'h0};
        run = 1'b1;
        for (int i = 0; i < 20 && illegal !== 1'b1; i++) @(negedge clk);
        tick(2);
        check("cnt_illegal_not_counted", {{(32-CW){1'b0}}, retired}, 1);
        do_reset();
        check("cnt_reset", {{(32-CW){1'b0}}, retired}, 0);
        tick(2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
